mul_div_unit: RTL

Sequential RV32M execution unit. Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU for R-type instructions that the control decoder tags with `ALU_OP_M` and a 3-bit `MUL_Opcode` (funct3). Sits beside the ALU in the execute stage. While an operation is in flight it holds the core via `Stall`, and its result feeds the ALU writeback path.

---
 rtl/mul_div_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: sequential RV32M multiply/divide unit for the execute stage.
// One multiplier or quotient bit is produced per cycle over 32 iterations.
// Divide-by-zero and signed overflow bypass the iteration loop.
// The core is held via Stall while an operation is outstanding.

module mul_div_unit (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [2:0]  MUL_Opcode,
  input  logic [31:0] Operand_A,
  input  logic [31:0] Operand_B,
  output logic [31:0] Result,
  output logic        Done,
  output logic        Busy,
  output logic        Stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [2:0]  op_q;
  logic [31:0] oper_q;
  logic [63:0] acc_q;
  logic [4:0]  cnt_q;
  logic        negQuot_q;
  logic        negRem_q;
  logic [31:0] result_q;
  logic        done_q;
  logic        busy_q;

  logic        signA;
  logic        signB;
  logic [31:0] magA;
  logic [31:0] magB;
  logic        divZero;
  logic        divOvf;
  logic [31:0] fastResult;

  logic [32:0] mulSum;
  logic [32:0] divShift;
  logic [32:0] divDiff;
  logic [63:0] acc_d;

  logic [63:0] prodFixed;
  logic [31:0] quotFixed;
  logic [31:0] remFixed;
  logic [31:0] finalResult;

  // Decode operand signedness, magnitudes and the bypass cases from the live request.
  always_comb begin
    signA      = 1'b0;
    signB      = 1'b0;
    fastResult = 32'h0;
    case (MUL_Opcode)
      3'b001, 3'b100, 3'b110: begin
        signA = Operand_A[31];
        signB = Operand_B[31];
      end
      3'b010: signA = Operand_A[31];
      default: ;
    endcase
    magA    = signA ? (32'h0 - Operand_A) : Operand_A;
    magB    = signB ? (32'h0 - Operand_B) : Operand_B;
    divZero = MUL_Opcode[2] & (Operand_B == 32'h0);
    divOvf  = MUL_Opcode[2] & ~MUL_Opcode[0] &
              (Operand_A == 32'h8000_0000) & (Operand_B == 32'hFFFF_FFFF);
    if (divZero) begin
      fastResult = MUL_Opcode[1] ? Operand_A : 32'hFFFF_FFFF;
    end else if (divOvf) begin
      fastResult = MUL_Opcode[1] ? 32'h0 : 32'h8000_0000;
    end
  end

  // One iteration step: shift-add for multiply, restoring subtract for divide.
  // acc holds {partial product high, multiplier} or {partial remainder, dividend/quotient}.
  always_comb begin
    mulSum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? oper_q : 32'h0)};
    divShift = acc_q[63:31];
    divDiff  = divShift - {1'b0, oper_q};
    if (op_q[2]) begin
      if (divDiff[32]) begin
        acc_d = {divShift[31:0], acc_q[30:0], 1'b0};
      end else begin
        acc_d = {divDiff[31:0], acc_q[30:0], 1'b1};
      end
    end else begin
      acc_d = {mulSum, acc_q[31:1]};
    end
  end

  // Apply the sign fixups to the final iteration and pick the requested half/part.
  always_comb begin
    prodFixed = negQuot_q ? (64'h0 - acc_d) : acc_d;
    quotFixed = negQuot_q ? (32'h0 - acc_d[31:0]) : acc_d[31:0];
    remFixed  = negRem_q ? (32'h0 - acc_d[63:32]) : acc_d[63:32];
    case (op_q)
      3'b000:                 finalResult = prodFixed[31:0];
      3'b001, 3'b010, 3'b011: finalResult = prodFixed[63:32];
      3'b100, 3'b101:         finalResult = quotFixed;
      default:                finalResult = remFixed;
    endcase
  end

  // Control FSM with registered Result/Done/Busy; reset aborts any operation in flight.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      op_q      <= 3'h0;
      oper_q    <= 32'h0;
      acc_q     <= 64'h0;
      cnt_q     <= 5'h0;
      negQuot_q <= 1'b0;
      negRem_q  <= 1'b0;
      result_q  <= 32'h0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (Start) begin
            op_q      <= MUL_Opcode;
            negQuot_q <= signA ^ signB;
            negRem_q  <= signA;
            cnt_q     <= 5'h0;
            oper_q    <= MUL_Opcode[2] ? magB : magA;
            acc_q     <= {32'h0, (MUL_Opcode[2] ? magA : magB)};
            if (divZero || divOvf) begin
              result_q <= fastResult;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_q <= finalResult;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Result = result_q;
  assign Done   = done_q;
  assign Busy   = busy_q;
  assign Stall  = Start & ~done_q;

endmodule
